// File: rtl/gift_data_out_buffer.sv
// GIFT ciphertext output buffer: DEPTH-entry block FIFO, head block serialised MS beat first.
// Optional sticky overflow flag outOvf is built when GIFT_OUT_BUF_OVF_EN is defined.
module gift_data_out_buffer #(
    parameter int BLOCK_W = 128,
    parameter int OUT_W   = 32,
    parameter int DEPTH   = 4
) (
    input  logic               inClk,
    input  logic               inRst,
    input  logic               inWr,
    input  logic [BLOCK_W-1:0] inData,
    output logic               outFull,
    output logic               outValid,
    input  logic               inReady,
    output logic [OUT_W-1:0]   outData,
    output logic               outLast
`ifdef GIFT_OUT_BUF_OVF_EN
    ,
    output logic               outOvf
`endif
);

    localparam int BEATS  = BLOCK_W / OUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W:0]     count;
    logic [BEAT_W-1:0]  beatIdx;
    logic               wrEn;
    logic               beatPop;
    logic               blockPop;
    logic               atLastBeat;

    // Fullness comes from the registered count, so a write while full is
    // dropped even if the head block retires on the same edge.
    assign outValid   = (count != '0);
    assign outFull    = (count == FULL_COUNT);
    assign atLastBeat = (beatIdx == LAST_BEAT);
    assign outLast    = outValid && atLastBeat;
    assign wrEn       = inWr && !outFull;
    assign beatPop    = outValid && inReady;
    assign blockPop   = beatPop && atLastBeat;
    assign outData    = OUT_W'(mem[rdPtr] >> ((BEATS - 1 - int'(beatIdx)) * OUT_W));

    // NOTE: storage has no reset; it is only ever read behind a valid count,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge inClk) begin
        if (!inRst && wrEn) begin
            mem[wrPtr] <= inData;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every update
    // in this block sees the pre-edge values of count/beatIdx.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            beatIdx <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (beatPop) begin
                beatIdx <= atLastBeat ? '0 : beatIdx + BEAT_W'(1);
            end
            if (blockPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({wrEn, blockPop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef GIFT_OUT_BUF_OVF_EN
    always_ff @(posedge inClk) begin
        if (inRst) begin
            outOvf <= 1'b0;
        end else if (inWr && outFull) begin
            outOvf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gift_data_out_buffer.sv
// Bench for gift_data_out_buffer: three instances (OUT_W 32/64/128) share stimulus and are
// compared against a queue-level reference model, plus directed tables and sequences.
module tb_gift_data_out_buffer;

    logic         inClk = 1'b0;
    logic         inRst;
    logic         inWr;
    logic         inReady;
    logic [127:0] inData;
    logic [31:0]  d32;
    logic [63:0]  d64;
    logic [127:0] d128;
    logic [2:0]   aValid;
    logic [2:0]   aLast;
    logic [2:0]   aFull;
`ifdef GIFT_OUT_BUF_OVF_EN
    logic [2:0]   aOvf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 inClk = ~inClk;

    gift_data_out_buffer #(.BLOCK_W(128), .OUT_W(32), .DEPTH(4)) dut32 (
        .inClk(inClk), .inRst(inRst), .inWr(inWr), .inData(inData),
        .outFull(aFull[0]), .outValid(aValid[0]), .inReady(inReady),
        .outData(d32), .outLast(aLast[0])
`ifdef GIFT_OUT_BUF_OVF_EN
        , .outOvf(aOvf[0])
`endif
    );

    gift_data_out_buffer #(.BLOCK_W(128), .OUT_W(64), .DEPTH(4)) dut64 (
        .inClk(inClk), .inRst(inRst), .inWr(inWr), .inData(inData),
        .outFull(aFull[1]), .outValid(aValid[1]), .inReady(inReady),
        .outData(d64), .outLast(aLast[1])
`ifdef GIFT_OUT_BUF_OVF_EN
        , .outOvf(aOvf[1])
`endif
    );

    gift_data_out_buffer #(.BLOCK_W(128), .OUT_W(128), .DEPTH(4)) dut128 (
        .inClk(inClk), .inRst(inRst), .inWr(inWr), .inData(inData),
        .outFull(aFull[2]), .outValid(aValid[2]), .inReady(inReady),
        .outData(d128), .outLast(aLast[2])
`ifdef GIFT_OUT_BUF_OVF_EN
        , .outOvf(aOvf[2])
`endif
    );

    // Reference model: per instance, an ordered list of held blocks (head at index 0),
    // the number of beats of the head already accepted, and the sticky overflow bit.
    logic [127:0] mq [3][8];
    int           mcnt [3];
    int           mk [3];
    bit           movf [3];

    function automatic int beatsOf(input int c);
        return 4 >> c;
    endfunction

    function automatic int widthOf(input int c);
        return 32 << c;
    endfunction

    function automatic logic [127:0] expData(input int c);
        logic [127:0] v;
        v = mq[c][0] >> ((beatsOf(c) - 1 - mk[c]) * widthOf(c));
        if (widthOf(c) < 128) v = v & ((128'(1) << widthOf(c)) - 128'(1));
        return v;
    endfunction

    function automatic logic [127:0] actData(input int c);
        case (c)
            0:       return 128'(d32);
            1:       return 128'(d64);
            default: return d128;
        endcase
    endfunction

    function automatic logic [127:0] mkBlk(input int n);
        return {32'(n * 16 + 1), 32'(n * 16 + 2), 32'(n * 16 + 3), 32'(n * 16 + 4)};
    endfunction

    task automatic modelEdge(input bit rst, input bit wr, input logic [127:0] data, input bit ready);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                mcnt[c] = 0;
                mk[c]   = 0;
                movf[c] = 1'b0;
            end else begin
                bit wasFull;
                wasFull = (mcnt[c] == 4);
                if (ready && mcnt[c] > 0) begin
                    if (mk[c] == beatsOf(c) - 1) begin
                        for (int j = 0; j < 7; j++) mq[c][j] = mq[c][j + 1];
                        mcnt[c]--;
                        mk[c] = 0;
                    end else begin
                        mk[c]++;
                    end
                end
                if (wr) begin
                    if (wasFull) begin
                        movf[c] = 1'b1;
                    end else begin
                        mq[c][mcnt[c]] = data;
                        mcnt[c]++;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("w%0d valid", widthOf(c)), 128'(aValid[c]), 128'(mcnt[c] != 0));
            check($sformatf("w%0d full", widthOf(c)), 128'(aFull[c]), 128'(mcnt[c] == 4));
            check($sformatf("w%0d last", widthOf(c)), 128'(aLast[c]),
                  128'(mcnt[c] != 0 && mk[c] == beatsOf(c) - 1));
            if (mcnt[c] != 0) check($sformatf("w%0d data", widthOf(c)), actData(c), expData(c));
`ifdef GIFT_OUT_BUF_OVF_EN
            check($sformatf("w%0d ovf", widthOf(c)), 128'(aOvf[c]), 128'(movf[c]));
`endif
        end
    endtask

    // Drive inputs away from the rising edge, advance the model, sample at the falling edge.
    task automatic step(input bit rst, input bit wr, input logic [127:0] data, input bit ready);
        inRst   = rst;
        inWr    = wr;
        inData  = data;
        inReady = ready;
        @(posedge inClk);
        modelEdge(rst, wr, data, ready);
        @(negedge inClk);
        checkAll();
    endtask

    typedef struct {
        bit           rst;
        bit           wr;
        logic [127:0] data;
        bit           ready;
        bit           eValid;
        logic [31:0]  eData;
        bit           eLast;
        bit           eFull;
    } vec_t;

    localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    initial begin
        vec_t tbl [6];
        logic [31:0] exp2 [4];
        int n;
        int guard;

        inRst = 1'b1; inWr = 1'b0; inReady = 1'b0; inData = '0;
        for (int c = 0; c < 3; c++) begin
            mcnt[c] = 0; mk[c] = 0; movf[c] = 1'b0;
        end

        // Test 1: single block, consumer always ready.
        tbl[0] = '{1'b1, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, BLK1,   1'b1, 1'b1, 32'h00112233, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'h44556677, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'h8899AABB, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'hCCDDEEFF, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].data, tbl[i].ready);
            check($sformatf("t1[%0d] valid", i), 128'(aValid[0]), 128'(tbl[i].eValid));
            check($sformatf("t1[%0d] last", i), 128'(aLast[0]), 128'(tbl[i].eLast));
            check($sformatf("t1[%0d] full", i), 128'(aFull[0]), 128'(tbl[i].eFull));
            if (tbl[i].eValid) check($sformatf("t1[%0d] data", i), 128'(d32), 128'(tbl[i].eData));
            if (i == 1) begin
                check("t1 w128 last", 128'(aLast[2]), 128'(1));
                check("t1 w128 data", d128, BLK1);
                check("t1 w64 data0", 128'(d64), 128'(64'h00112233_44556677));
            end
            if (i == 2) begin
                check("t1 w64 last", 128'(aLast[1]), 128'(1));
                check("t1 w64 data1", 128'(d64), 128'(64'h8899AABB_CCDDEEFF));
                check("t1 w128 empty", 128'(aValid[2]), 128'(0));
            end
        end

        // Test 2: backpressure holds the first beat, release gives the full sequence.
        exp2[0] = 32'h00112233; exp2[1] = 32'h44556677; exp2[2] = 32'h8899AABB; exp2[3] = 32'hCCDDEEFF;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, BLK1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            check("t2 hold valid", 128'(aValid[0]), 128'(1));
            check("t2 hold data", 128'(d32), 128'(32'h00112233));
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2 beat%0d", k), 128'(d32), 128'(exp2[k]));
            check($sformatf("t2 last%0d", k), 128'(aLast[0]), 128'(k == 3));
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check("t2 drained", 128'(aValid[0]), 128'(0));

        // Test 3: fill to full, drop a fifth write, drain in order.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            step(1'b0, 1'b1, mkBlk(b), 1'b0);
            check($sformatf("t3 full after %0d", b + 1), 128'(aFull[0]), 128'(b == 3));
        end
        step(1'b0, 1'b1, mkBlk(4), 1'b0);
        check("t3 full after drop", 128'(aFull[0]), 128'(1));
`ifdef GIFT_OUT_BUF_OVF_EN
        check("t3 ovf", 128'(aOvf[0]), 128'(1));
`endif
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                logic [127:0] blk;
                blk = mkBlk(b);
                check($sformatf("t3 blk%0d beat%0d", b, k), 128'(d32), 128'(blk[127 - k * 32 -: 32]));
                step(1'b0, 1'b0, '0, 1'b1);
            end
        end
        check("t3 no E", 128'(aValid[0]), 128'(0));

        // Test 4: hold two blocks and refill on every final-beat pop.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, mkBlk(20), 1'b0);
        step(1'b0, 1'b1, mkBlk(21), 1'b0);
        n = 2;
        guard = 0;
        while (n < 10 && guard < 100) begin
            bit w;
            w = (mk[0] == 3);
            step(1'b0, w, mkBlk(20 + n), 1'b1);
            if (w) n++;
            check("t4 not full", 128'(aFull[0]), 128'(0));
            check("t4 valid", 128'(aValid[0]), 128'(1));
            guard++;
        end
        check("t4 all written", 128'(n), 128'(10));
        guard = 0;
        while (mcnt[0] != 0 && guard < 40) begin
            step(1'b0, 1'b0, '0, 1'b1);
            guard++;
        end
        check("t4 drained", 128'(aValid[0]), 128'(0));

        // Test 5: reset in the middle of a block with three blocks queued.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int b = 0; b < 3; b++) step(1'b0, 1'b1, mkBlk(40 + b), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("t5 mid-block data", 128'(d32), 128'(32'(40 * 16 + 3)));
        step(1'b1, 1'b0, '0, 1'b1);
        check("t5 valid", 128'(aValid[0]), 128'(0));
        check("t5 full", 128'(aFull[0]), 128'(0));
`ifdef GIFT_OUT_BUF_OVF_EN
        check("t5 ovf", 128'(aOvf[0]), 128'(0));
`endif
        step(1'b0, 1'b1, BLK1, 1'b0);
        check("t5 restart beat0", 128'(d32), 128'(32'h00112233));
        check("t5 restart last", 128'(aLast[0]), 128'(0));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic with phases of light and heavy backpressure.
        for (int i = 0; i < 600; i++) begin
            bit rst;
            bit wr;
            bit rdy;
            logic [127:0] d;
            rst = ($urandom_range(0, 79) == 0);
            wr  = ($urandom_range(0, 2) != 0);
            rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            d   = {$urandom, $urandom, $urandom, $urandom};
            step(rst, wr, d, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
